// File: rtl/nn_frame_sequencer.sv
`default_nettype none
// nn_frame_sequencer: gathers 7 feature words into a frame, runs neural_network for a
// fixed settle window, then presents the captured result on a valid/ready port.  Rev 1.0
module nn_frame_sequencer #(
  parameter int DW            = 17,
  parameter int SETTLE_CYCLES = 200,
  parameter int CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          nn_ce,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] x5,
  output logic [DW-1:0] x6,
  output logic [DW-1:0] x7,
  input  logic [DW-1:0] nn_y,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          frame_err,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX = 3'd6;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       widx;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign s_ready = (state == LOAD);
  assign busy    = (state != LOAD);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      widx      <= 3'd0;
      cnt       <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      x4        <= '0;
      x5        <= '0;
      x6        <= '0;
      x7        <= '0;
      m_data    <= '0;
      nn_ce     <= 1'b0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            case (widx)
              3'd0:    x1 <= s_data;
              3'd1:    x2 <= s_data;
              3'd2:    x3 <= s_data;
              3'd3:    x4 <= s_data;
              3'd4:    x5 <= s_data;
              3'd5:    x6 <= s_data;
              3'd6:    x7 <= s_data;
              default: ;
            endcase
            // A misplaced or missing s_last drops the partial frame and resynchronises.
            if (widx == LAST_IDX) begin
              widx <= 3'd0;
              if (s_last) begin
                state <= RUN;
                nn_ce <= 1'b1;
                cnt   <= '0;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (s_last) begin
              widx      <= 3'd0;
              frame_err <= 1'b1;
            end else begin
              widx <= widx + 3'd1;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            m_data  <= nn_y;
            nn_ce   <= 1'b0;
            m_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_frame_sequencer.sv
`default_nettype none
// tb_nn_frame_sequencer: scoreboard bench for nn_frame_sequencer with a stub network
// (y = x1 + x7 while ce is high).  Rev 1.0
module tb_nn_frame_sequencer;

  localparam int DW     = 17;
  localparam int SETTLE = 200;

  typedef logic [DW-1:0] frame_t [7];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          nn_ce;
  logic [DW-1:0] x1, x2, x3, x4, x5, x6, x7;
  logic [DW-1:0] nn_y;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          frame_err;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] sb [$];

  nn_frame_sequencer #(.DW(DW), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .nn_ce(nn_ce), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5),
    .x6(x6), .x7(x7), .nn_y(nn_y), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub network: output updates only while enabled, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) nn_y <= '0;
    else if (nn_ce) nn_y <= x1 + x7;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last, input int gap_max);
    int  n;
    bit  acc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 2000) begin
      acc = s_ready;
      tick();
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) begin
      failures++;
      $display("FAIL send_word_timeout s_ready=%b required=1", s_ready);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "input handshake never completed");
    end
  endtask

  task automatic send_frame(input frame_t f, input int last_pos, input int nwords, input int gap_max);
    for (int i = 0; i < nwords; i++) send_word(f[i], (i == last_pos), gap_max);
  endtask

  task automatic wait_mvalid(output int edges, output int ce_cnt);
    edges  = 0;
    ce_cnt = 0;
    while (!m_valid && edges < SETTLE + 50) begin
      if (nn_ce) ce_cnt++;
      tick();
      edges++;
    end
  endtask

  task automatic run_result(output logic got_valid, output logic [DW-1:0] got_data);
    int e, c;
    wait_mvalid(e, c);
    got_valid = m_valid;
    got_data  = m_data;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++;
    if ({s_ready, nn_ce, m_valid, frame_err, busy} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl {s_ready,ce,mv,err,busy}=%b required=10000",
               {s_ready, nn_ce, m_valid, frame_err, busy});
    end
    checks++;
    if ((x1 | x2 | x3 | x4 | x5 | x6 | x7 | m_data) !== '0) begin
      failures++;
      $display("FAIL reset_data x1=%h x7=%h m_data=%h required=0", x1, x7, m_data);
    end
  endtask

  task automatic test_nominal();
    frame_t f = '{17'h0DED, 17'h0979, 17'h0636, 17'h05A5, 17'h0A8A, 17'h0191, 17'h0373};
    frame_t xs;
    int e, c;
    logic [DW-1:0] exp;
    sb.push_back(17'h1160);
    send_frame(f, 6, 7, 0);
    xs = '{x1, x2, x3, x4, x5, x6, x7};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (xs[i] !== f[i]) begin
        failures++;
        $display("FAIL nominal_x%0d got=%h required=%h", i + 1, xs[i], f[i]);
      end
    end
    checks++;
    if ({nn_ce, busy, s_ready} !== 3'b110) begin
      failures++;
      $display("FAIL nominal_run {ce,busy,s_ready}=%b required=110", {nn_ce, busy, s_ready});
    end
    wait_mvalid(e, c);
    checks++;
    if (m_valid !== 1'b1 || e != SETTLE) begin
      failures++;
      $display("FAIL nominal_latency m_valid=%b edges_after_last=%0d required=%0d", m_valid, e, SETTLE);
    end
    checks++;
    if (c != SETTLE || nn_ce !== 1'b0) begin
      failures++;
      $display("FAIL nominal_ce_cycles got=%0d ce_now=%b required=%0d,0", c, nn_ce, SETTLE);
    end
    exp = sb.pop_front();
    checks++;
    if (m_data !== exp) begin
      failures++;
      $display("FAIL nominal_m_data got=%h required=%h", m_data, exp);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if ({m_valid, s_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL nominal_release {mv,s_ready,busy}=%b required=010", {m_valid, s_ready, busy});
    end
  endtask

  task automatic test_backpressure();
    frame_t f = '{17'h1ABCD, 17'h00011, 17'h00022, 17'h00033, 17'h00044, 17'h00055, 17'h04321};
    int e, c;
    bit ok;
    logic [DW-1:0] exp;
    sb.push_back(17'h1EEEE);
    send_frame(f, 6, 7, 0);
    wait_mvalid(e, c);
    exp = sb.pop_front();
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp) begin
      failures++;
      $display("FAIL bp_result m_valid=%b m_data=%h required=1,%h", m_valid, m_data, exp);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      ok = (m_valid === 1'b1) && (m_data === exp) && (s_ready === 1'b0) && (nn_ce === 1'b0) &&
           (x1 === f[0]) && (x4 === f[3]) && (x7 === f[6]) && (busy === 1'b1);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d mv=%b m_data=%h s_ready=%b ce=%b x1=%h x7=%h required=1,%h,0,0,%h,%h",
                 i, m_valid, m_data, s_ready, nn_ce, x1, x7, exp, f[0], f[6]);
      end
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release {s_ready,mv}=%b required=10", {s_ready, m_valid});
    end
  endtask

  task automatic test_early_last();
    frame_t f = '{17'h00AAA, 17'h00BBB, 17'h00CCC, 17'h0, 17'h0, 17'h0, 17'h0};
    frame_t g = '{17'h1F00F, 17'h00123, 17'h00456, 17'h00789, 17'h10ABC, 17'h0DEF0, 17'h01234};
    logic gv;
    logic [DW-1:0] gd, exp;
    send_frame(f, 2, 3, 0);
    checks++;
    if ({frame_err, nn_ce, s_ready} !== 3'b101) begin
      failures++;
      $display("FAIL early_err {err,ce,s_ready}=%b required=101", {frame_err, nn_ce, s_ready});
    end
    tick();
    checks++;
    if ({frame_err, nn_ce} !== 2'b00) begin
      failures++;
      $display("FAIL early_pulse {err,ce}=%b required=00", {frame_err, nn_ce});
    end
    sb.push_back(17'h00243);
    send_frame(g, 6, 7, 0);
    run_result(gv, gd);
    exp = sb.pop_front();
    checks++;
    if (gv !== 1'b1 || gd !== exp) begin
      failures++;
      $display("FAIL early_recover m_valid=%b m_data=%h required=1,%h", gv, gd, exp);
    end
  endtask

  task automatic test_missing_last();
    frame_t f = '{17'h11111, 17'h02222, 17'h03333, 17'h04444, 17'h05555, 17'h06666, 17'h07777};
    frame_t g = '{17'h00100, 17'h00200, 17'h00300, 17'h00400, 17'h00500, 17'h00600, 17'h00007};
    logic gv;
    logic [DW-1:0] gd, exp;
    send_frame(f, 7, 7, 0);
    checks++;
    if ({frame_err, nn_ce, busy, s_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL missing_err {err,ce,busy,s_ready}=%b required=1001", {frame_err, nn_ce, busy, s_ready});
    end
    sb.push_back(17'h00107);
    send_frame(g, 6, 7, 0);
    checks++;
    if (x1 !== g[0] || x7 !== g[6] || nn_ce !== 1'b1) begin
      failures++;
      $display("FAIL missing_realign x1=%h x7=%h ce=%b required=%h,%h,1", x1, x7, nn_ce, g[0], g[6]);
    end
    run_result(gv, gd);
    exp = sb.pop_front();
    checks++;
    if (gv !== 1'b1 || gd !== exp) begin
      failures++;
      $display("FAIL missing_result m_valid=%b m_data=%h required=1,%h", gv, gd, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    frame_t f = '{17'h0F0F0, 17'h01010, 17'h02020, 17'h03030, 17'h04040, 17'h05050, 17'h00F0F};
    send_frame(f, 6, 7, 0);
    repeat (100) tick();
    checks++;
    if ({nn_ce, busy} !== 2'b11) begin
      failures++;
      $display("FAIL midrun_active {ce,busy}=%b required=11", {nn_ce, busy});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({nn_ce, m_valid, s_ready, busy} !== 4'b0010 ||
        (x1 | x2 | x3 | x4 | x5 | x6 | x7) !== '0) begin
      failures++;
      $display("FAIL midrun_reset {ce,mv,s_ready,busy}=%b x1=%h x7=%h required=0010,0,0",
               {nn_ce, m_valid, s_ready, busy}, x1, x7);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    m_ready = 1'b1;
    fork
      begin
        frame_t f;
        for (int k = 0; k < 4; k++) begin
          for (int i = 0; i < 7; i++) f[i] = DW'($urandom);
          sb.push_back(f[0] + f[6]);
          send_frame(f, 6, 7, 3);
        end
      end
      begin
        int n = 0;
        logic [DW-1:0] exp;
        while (got < 4 && n < 4 * (SETTLE + 100)) begin
          tick();
          n++;
          if (m_valid) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL b2b_extra m_data=%h required=no_result", m_data);
            end else begin
              exp = sb.pop_front();
              if (m_data !== exp) begin
                failures++;
                $display("FAIL b2b_result idx=%0d got=%h required=%h", got, m_data, exp);
              end
            end
            got++;
          end
        end
      end
    join
    m_ready = 1'b0;
    checks++;
    if (got != 4 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count results=%0d pending=%0d required=4,0", got, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
